// File: rtl/prog_loader_pkg.sv
// Shared definitions for the ACC program loader: FSM state encoding,
// frame magic byte and default memory geometry.
package prog_loader_pkg;

    // Start-of-frame marker on the host byte link
    localparam logic [7:0]  MAGIC          = 8'hA5;

    // Default program RAM geometry
    localparam int unsigned AW_DEF         = 12;
    localparam logic [11:0] BOOT_ADDR_DEF  = 12'h800;
    localparam int unsigned NWORDS_DEF     = 2048;

    // Loader FSM states
    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_LEN_H  = 4'd1,
        ST_LEN_L  = 4'd2,
        ST_DATA_H = 4'd3,
        ST_DATA_L = 4'd4,
        ST_WRITE  = 4'd5,
        ST_CSUM   = 4'd6,
        ST_DONE   = 4'd7,
        ST_ERROR  = 4'd8
    } state_e;

    // States that wait for a new frame rather than being inside one
    function automatic logic is_rest_state(input state_e s);
        return (s == ST_IDLE) || (s == ST_DONE) || (s == ST_ERROR);
    endfunction

endpackage

// File: rtl/prog_loader_csum8.sv
// 8-bit XOR accumulator used to verify the frame checksum.
// Clear has priority over enable; the sum is available one cycle after
// the byte that updated it.
module csum8 (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       clr_i,
    input  logic       en_i,
    input  logic [7:0] data_i,
    output logic [7:0] sum_o
);

    logic [7:0] sum_q;
    logic [7:0] sum_d;

    // Next value of the running XOR
    always_comb begin
        sum_d = sum_q;
        if (clr_i) begin
            sum_d = 8'h00;
        end else if (en_i) begin
            sum_d = sum_q ^ data_i;
        end else begin
            sum_d = sum_q;
        end
    end

    // Accumulator register
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            sum_q <= 8'h00;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign sum_o = sum_q;

endmodule

// File: rtl/prog_loader.sv
// Program loader for the ACC core instruction memory.
// Receives a framed byte stream (A5, LEN_H, LEN_L, LEN x {hi, lo}
// [, CSUM]), writes big-endian 16-bit words starting at BOOT_ADDR and
// keeps the core in reset until a complete image has been loaded.
// Optional feature macro: PROG_LOADER_CSUM_EN enables the trailing
// XOR checksum byte and its verification.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int unsigned    AW        = AW_DEF,
    parameter int unsigned    DW        = 16,
    parameter logic [AW-1:0]  BOOT_ADDR = BOOT_ADDR_DEF,
    parameter int unsigned    NWORDS    = NWORDS_DEF
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic [7:0]    rx_data,
    input  logic          rx_valid,
    output logic          rx_ready,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    output logic          mem_we,
    output logic          cpu_rst,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam logic [15:0] NWORDS_W = 16'(NWORDS);

    // State entered once the last data word has been written (or LEN=0)
`ifdef PROG_LOADER_CSUM_EN
    localparam state_e ST_TAIL = ST_CSUM;
`else
    localparam state_e ST_TAIL = ST_DONE;
`endif

    state_e          state_q, state_d;
    logic [15:0]     len_q,   len_d;
    logic [15:0]     idx_q,   idx_d;
    logic [7:0]      hi_q,    hi_d;
    logic [AW-1:0]   addr_q,  addr_d;
    logic [DW-1:0]   din_q,   din_d;
    logic [15:0]     len_w_s;
    logic            accept_s;

    assign accept_s = rx_valid && rx_ready;
    assign len_w_s  = {len_q[15:8], rx_data};

`ifdef PROG_LOADER_CSUM_EN
    logic       csum_clr_s;
    logic       csum_en_s;
    logic [7:0] csum_s;

    // Checksum control: restart on MAGIC, fold in length and data bytes
    always_comb begin
        csum_clr_s = 1'b0;
        csum_en_s  = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                csum_clr_s = accept_s && (rx_data == MAGIC);
            end
            ST_LEN_H, ST_LEN_L, ST_DATA_H, ST_DATA_L: begin
                csum_en_s = accept_s;
            end
            default: begin
                csum_clr_s = 1'b0;
                csum_en_s  = 1'b0;
            end
        endcase
    end

    csum8 u_csum8 (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .clr_i  (csum_clr_s),
        .en_i   (csum_en_s),
        .data_i (rx_data),
        .sum_o  (csum_s)
    );
`endif

    // Frame parser: next state plus length, index and write-data capture
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        hi_d    = hi_q;
        addr_d  = addr_q;
        din_d   = din_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (accept_s && (rx_data == MAGIC)) begin
                    state_d = ST_LEN_H;
                end else begin
                    state_d = state_q;
                end
            end
            ST_LEN_H: begin
                if (accept_s) begin
                    len_d   = {rx_data, 8'h00};
                    state_d = ST_LEN_L;
                end else begin
                    state_d = state_q;
                end
            end
            ST_LEN_L: begin
                if (accept_s) begin
                    len_d = len_w_s;
                    idx_d = 16'h0000;
                    if (len_w_s > NWORDS_W) begin
                        state_d = ST_ERROR;
                    end else if (len_w_s == 16'h0000) begin
                        state_d = ST_TAIL;
                    end else begin
                        state_d = ST_DATA_H;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ST_DATA_H: begin
                if (accept_s) begin
                    hi_d    = rx_data;
                    state_d = ST_DATA_L;
                end else begin
                    state_d = state_q;
                end
            end
            ST_DATA_L: begin
                if (accept_s) begin
                    // Address wraps modulo 2^AW by truncation
                    addr_d  = BOOT_ADDR + idx_q[AW-1:0];
                    din_d   = {hi_q, rx_data};
                    state_d = ST_WRITE;
                end else begin
                    state_d = state_q;
                end
            end
            ST_WRITE: begin
                idx_d = idx_q + 16'd1;
                if ((idx_q + 16'd1) == len_q) begin
                    state_d = ST_TAIL;
                end else begin
                    state_d = ST_DATA_H;
                end
            end
`ifdef PROG_LOADER_CSUM_EN
            ST_CSUM: begin
                if (accept_s) begin
                    if (rx_data == csum_s) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ERROR;
                    end
                end else begin
                    state_d = state_q;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= ST_IDLE;
            len_q   <= 16'h0000;
            idx_q   <= 16'h0000;
            hi_q    <= 8'h00;
            addr_q  <= BOOT_ADDR;
            din_q   <= {DW{1'b0}};
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            hi_q    <= hi_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
        end
    end

    // Status and handshake outputs decoded from the state register only
    always_comb begin
        rx_ready = 1'b1;
        mem_we   = 1'b0;
        cpu_rst  = 1'b1;
        busy     = !is_rest_state(state_q);
        done     = 1'b0;
        err      = 1'b0;
        case (state_q)
            ST_WRITE: begin
                rx_ready = 1'b0;
                mem_we   = 1'b1;
            end
            ST_DONE: begin
                done    = 1'b1;
                cpu_rst = 1'b0;
            end
            ST_ERROR: begin
                err = 1'b1;
            end
            default: begin
                rx_ready = 1'b1;
                mem_we   = 1'b0;
            end
        endcase
    end

    assign mem_addr = addr_q;
    assign mem_din  = din_q;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: an abstract frame-level model
// predicts writes and status every cycle; directed frames with literal
// expectations pin the model.
module tb_prog_loader;

`ifdef PROG_LOADER_CSUM_EN
    localparam bit CSUM_ON = 1'b1;
`else
    localparam bit CSUM_ON = 1'b0;
`endif

    localparam int M_IDLE  = 0;
    localparam int M_FRAME = 1;
    localparam int M_WPEND = 2;
    localparam int M_DONE  = 3;
    localparam int M_ERR   = 4;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [11:0] mem_addr;
    logic [15:0] mem_din;
    logic        mem_we;
    logic        cpu_rst;
    logic        busy;
    logic        done;
    logic        err;

    int n_vec = 0;
    int n_err = 0;

    // model state
    int          m_mode = M_IDLE;
    int          m_next = M_IDLE;
    int          m_pos  = 0;
    logic [15:0] m_len  = 16'h0000;
    logic [7:0]  m_lenh = 8'h00;
    logic [7:0]  m_hi   = 8'h00;
    logic [7:0]  m_xor  = 8'h00;
    logic [11:0] q_addr[$];
    logic [15:0] q_data[$];

    // observed write log
    int          obs_cnt = 0;
    logic [11:0] obs_addr[32];
    logic [15:0] obs_data[32];

    prog_loader dut (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .mem_addr (mem_addr),
        .mem_din  (mem_din),
        .mem_we   (mem_we),
        .cpu_rst  (cpu_rst),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE;
        m_pos  = 0;
        m_xor  = 8'h00;
        q_addr.delete();
        q_data.delete();
    endtask

    // Frame-level interpretation of one accepted byte
    task automatic model_accept(input logic [7:0] b);
        int k;
        if (m_mode == M_FRAME) begin
            if (m_pos == 0) begin
                m_lenh = b;
                m_xor  = m_xor ^ b;
            end else if (m_pos == 1) begin
                m_len = {m_lenh, b};
                m_xor = m_xor ^ b;
                if (m_len > 16'd2048) m_mode = M_ERR;
                else if (m_len == 16'd0 && !CSUM_ON) m_mode = M_DONE;
            end else if (m_pos < 2 + 2 * int'(m_len)) begin
                k = m_pos - 2;
                m_xor = m_xor ^ b;
                if (k % 2 == 0) begin
                    m_hi = b;
                end else begin
                    q_addr.push_back(12'h800 + 12'(k / 2));
                    q_data.push_back({m_hi, b});
                    m_next = ((k / 2 == int'(m_len) - 1) && !CSUM_ON) ? M_DONE : M_FRAME;
                    m_mode = M_WPEND;
                end
            end else begin
                m_mode = (b == m_xor) ? M_DONE : M_ERR;
            end
            m_pos++;
        end else if (m_mode != M_WPEND) begin
            if (b == 8'hA5) begin
                m_mode = M_FRAME;
                m_pos  = 0;
                m_xor  = 8'h00;
            end
        end
    endtask

    // Per-cycle compare against the model, sampled on the falling edge
    always @(negedge clk_in) begin
        if (rst_in) begin
            model_reset();
            chk("rst_rx_ready", {31'd0, rx_ready}, 32'd1);
            chk("rst_mem_we",   {31'd0, mem_we},   32'd0);
            chk("rst_cpu_rst",  {31'd0, cpu_rst},  32'd1);
            chk("rst_busy",     {31'd0, busy},     32'd0);
            chk("rst_done",     {31'd0, done},     32'd0);
            chk("rst_err",      {31'd0, err},      32'd0);
            chk("rst_mem_addr", {20'd0, mem_addr}, 32'h800);
        end else begin
            chk("rx_ready", {31'd0, rx_ready}, {31'd0, (m_mode != M_WPEND)});
            chk("mem_we",   {31'd0, mem_we},   {31'd0, (m_mode == M_WPEND)});
            chk("busy",     {31'd0, busy},     {31'd0, (m_mode == M_FRAME || m_mode == M_WPEND)});
            chk("done",     {31'd0, done},     {31'd0, (m_mode == M_DONE)});
            chk("err",      {31'd0, err},      {31'd0, (m_mode == M_ERR)});
            chk("cpu_rst",  {31'd0, cpu_rst},  {31'd0, (m_mode != M_DONE)});
            if (mem_we) begin
                if (obs_cnt < 32) begin
                    obs_addr[obs_cnt] = mem_addr;
                    obs_data[obs_cnt] = mem_din;
                end
                obs_cnt++;
                if (q_addr.size() == 0) begin
                    chk("unexpected_write", {20'd0, mem_addr}, 32'hFFFF_FFFF);
                end else begin
                    chk("write_addr", {20'd0, mem_addr}, {20'd0, q_addr.pop_front()});
                    chk("write_data", {16'd0, mem_din},  {16'd0, q_data.pop_front()});
                end
                if (m_mode == M_WPEND) m_mode = m_next;
            end
            if (rx_valid && rx_ready) model_accept(rx_data);
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    // Present one byte until it is accepted, then leave gap idle cycles
    task automatic send(input logic [7:0] b, input int gap);
        logic acc;
        acc      = 1'b0;
        rx_data  = b;
        rx_valid = 1'b1;
        for (int t = 0; t < 20 && !acc; t++) begin
            @(negedge clk_in);
            acc = rx_ready;
            @(posedge clk_in);
            #1;
        end
        if (!acc) chk("accept_timeout", 32'd0, 32'd1);
        rx_valid = 1'b0;
        for (int g = 0; g < gap; g++) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    // Send n bytes held in v, first byte in the most significant position
    task automatic send_bytes(input logic [127:0] v, input int n, input int gap);
        for (int i = 0; i < n; i++) send(v[8*(n-1-i) +: 8], gap);
    endtask

    initial begin
        rst_in   = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (2) @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        idle(1);
        chk("idle_ready",    {31'd0, rx_ready}, 32'd1);
        chk("idle_cpu_rst",  {31'd0, cpu_rst},  32'd1);
        chk("idle_mem_addr", {20'd0, mem_addr}, 32'h800);

        // Frame 1, back to back, with leading junk
        send_bytes({8'h00, 8'hFF, 8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42}, 10, 0);
        idle(4);
        chk("f1_xor",    {24'd0, m_xor},       32'h42);
        chk("f1_count",  obs_cnt,              32'd2);
        chk("f1_a0",     {20'd0, obs_addr[0]}, 32'h800);
        chk("f1_d0",     {16'd0, obs_data[0]}, 32'h1234);
        chk("f1_a1",     {20'd0, obs_addr[1]}, 32'h801);
        chk("f1_d1",     {16'd0, obs_data[1]}, 32'hABCD);
        chk("f1_done",   {31'd0, done},        32'd1);
        chk("f1_cpu_rst",{31'd0, cpu_rst},     32'd0);

        // Same frame with a wrong checksum byte
        send_bytes({8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h43}, 8, 0);
        idle(4);
        chk("f2_count",  obs_cnt,              32'd4);
        chk("f2_d1",     {16'd0, obs_data[3]}, 32'hABCD);
        chk("f2_err",    {31'd0, err},         {31'd0, CSUM_ON});
        chk("f2_done",   {31'd0, done},        {31'd0, !CSUM_ON});
        chk("f2_cpu_rst",{31'd0, cpu_rst},     {31'd0, CSUM_ON});

        // Oversize length 2049
        send_bytes({8'hA5, 8'h08, 8'h01}, 3, 0);
        idle(4);
        chk("f3_count",  obs_cnt,          32'd4);
        chk("f3_err",    {31'd0, err},     32'd1);
        chk("f3_cpu_rst",{31'd0, cpu_rst}, 32'd1);

        // Frame 1 again with rx_valid toggling every other cycle
        send_bytes({8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42}, 8, 1);
        idle(4);
        chk("f4_count",  obs_cnt,              32'd6);
        chk("f4_a0",     {20'd0, obs_addr[4]}, 32'h800);
        chk("f4_d0",     {16'd0, obs_data[4]}, 32'h1234);
        chk("f4_a1",     {20'd0, obs_addr[5]}, 32'h801);
        chk("f4_d1",     {16'd0, obs_data[5]}, 32'hABCD);
        chk("f4_done",   {31'd0, done},        32'd1);

        // Reset pulse after the first word of a frame
        send_bytes({8'hA5, 8'h00, 8'h02, 8'h11, 8'h22}, 5, 0);
        idle(2);
        chk("f5_count",  obs_cnt,              32'd7);
        chk("f5_d0",     {16'd0, obs_data[6]}, 32'h1122);
        chk("f5_busy",   {31'd0, busy},        32'd1);
        rst_in = 1'b1;
        #1;
        chk("f5_rst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        chk("f5_rst_busy",    {31'd0, busy},    32'd0);
        idle(2);
        rst_in = 1'b0;
        idle(1);
        send_bytes({8'hA5, 8'h00, 8'h01, 8'h55, 8'h66, 8'h33}, 6, 0);
        idle(4);
        chk("f6_count",  obs_cnt,              32'd8);
        chk("f6_a0",     {20'd0, obs_addr[7]}, 32'h800);
        chk("f6_d0",     {16'd0, obs_data[7]}, 32'h5566);
        chk("f6_done",   {31'd0, done},        {31'd0, !CSUM_ON});
        chk("f6_err",    {31'd0, err},         {31'd0, CSUM_ON});

        chk("pending_writes", q_addr.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
